lockin_iq_demod: RTL

- Consumer side of the sin/cos reference generator: takes ADC samples and the 8-bit offset-binary sin/cos reference codes.
- Each accepted sample is multiplied by both references (I = sig·sin, Q = sig·cos).
- Products are integrated over a fixed block of 2^LOG2_N accepted samples (integrate-and-dump boxcar low-pass), and the block mean is emitted as I/Q with a one-cycle valid pulse.
- Sits between the ADC front end and the magnitude/phase post-processing.

---
 rtl/lockin_iq_demod.sv | 133 +++++++++++++
 1 files changed

// File: rtl/lockin_iq_demod.sv
// lockin_iq_demod: I/Q lock-in demodulator that multiplies ADC samples by sin/cos references
// and dumps the arithmetic-shifted boxcar mean every 2^LOG2_N accepted samples.
module lockin_iq_demod #(
    parameter int SIG_W  = 12,
    parameter int REF_W  = 8,
    parameter int LOG2_N = 10
) (
    input  logic                     sys_clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     sig_valid,
    input  logic [SIG_W-1:0]         sig_in,
    input  logic [REF_W-1:0]         ref_sin,
    input  logic [REF_W-1:0]         ref_cos,
    output logic [SIG_W+REF_W-1:0]   i_out,
    output logic [SIG_W+REF_W-1:0]   q_out,
    output logic                     iq_valid,
    output logic [LOG2_N-1:0]        blk_cnt
);
    localparam int P_W   = SIG_W + REF_W;
    localparam int ACC_W = P_W + LOG2_N;

    logic                    r_v0;
    logic [SIG_W-1:0]        r_s0;
    logic [REF_W-1:0]        r_sin0;
    logic [REF_W-1:0]        r_cos0;
    logic                    r_v1;
    logic [P_W-1:0]          r_pi;
    logic [P_W-1:0]          r_pq;
    logic [ACC_W-1:0]        r_acc_i;
    logic [ACC_W-1:0]        r_acc_q;
    logic [P_W-1:0]          r_i_out;
    logic [P_W-1:0]          r_q_out;
    logic                    r_iq_valid;
    logic [LOG2_N-1:0]       r_blk_cnt;

    logic [REF_W-1:0]        w_sin;
    logic [REF_W-1:0]        w_cos;
    logic signed [P_W-1:0]   w_s_x;
    logic signed [P_W-1:0]   w_sin_x;
    logic signed [P_W-1:0]   w_cos_x;
    logic signed [P_W-1:0]   w_pi;
    logic signed [P_W-1:0]   w_pq;
    logic [ACC_W-1:0]        w_sum_i;
    logic [ACC_W-1:0]        w_sum_q;
    logic                    w_last;

    // Offset-binary to two's complement is just an MSB flip.
    assign w_sin = {~ref_sin[REF_W-1], ref_sin[REF_W-2:0]};
    assign w_cos = {~ref_cos[REF_W-1], ref_cos[REF_W-2:0]};

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v0   <= 1'b0;
            r_s0   <= '0;
            r_sin0 <= '0;
            r_cos0 <= '0;
        end else if (clear) begin
            r_v0 <= 1'b0;
        end else begin
            r_v0 <= sig_valid;
            if (sig_valid) begin
                r_s0   <= sig_in;
                r_sin0 <= w_sin;
                r_cos0 <= w_cos;
            end
        end
    end

    assign w_s_x   = {{REF_W{r_s0[SIG_W-1]}}, r_s0};
    assign w_sin_x = {{SIG_W{r_sin0[REF_W-1]}}, r_sin0};
    assign w_cos_x = {{SIG_W{r_cos0[REF_W-1]}}, r_cos0};
    assign w_pi    = w_s_x * w_sin_x;
    assign w_pq    = w_s_x * w_cos_x;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_pi <= '0;
            r_pq <= '0;
        end else if (clear) begin
            r_v1 <= 1'b0;
        end else begin
            r_v1 <= r_v0;
            if (r_v0) begin
                r_pi <= w_pi;
                r_pq <= w_pq;
            end
        end
    end

    assign w_sum_i = r_acc_i + {{LOG2_N{r_pi[P_W-1]}}, r_pi};
    assign w_sum_q = r_acc_q + {{LOG2_N{r_pq[P_W-1]}}, r_pq};
    assign w_last  = &r_blk_cnt;

    // The top P_W bits of the widened sum are exactly the floor-shifted block mean.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc_i    <= '0;
            r_acc_q    <= '0;
            r_i_out    <= '0;
            r_q_out    <= '0;
            r_iq_valid <= 1'b0;
            r_blk_cnt  <= '0;
        end else if (clear) begin
            r_acc_i    <= '0;
            r_acc_q    <= '0;
            r_iq_valid <= 1'b0;
            r_blk_cnt  <= '0;
        end else begin
            r_iq_valid <= 1'b0;
            if (r_v1) begin
                if (w_last) begin
                    r_i_out    <= w_sum_i[ACC_W-1 -: P_W];
                    r_q_out    <= w_sum_q[ACC_W-1 -: P_W];
                    r_acc_i    <= '0;
                    r_acc_q    <= '0;
                    r_blk_cnt  <= '0;
                    r_iq_valid <= 1'b1;
                end else begin
                    r_acc_i   <= w_sum_i;
                    r_acc_q   <= w_sum_q;
                    r_blk_cnt <= r_blk_cnt + 1'b1;
                end
            end
        end
    end

    assign i_out    = r_i_out;
    assign q_out    = r_q_out;
    assign iq_valid = r_iq_valid;
    assign blk_cnt  = r_blk_cnt;
endmodule
